// File: rtl/rst_release_seq_if.sv
// Reset sequencer bundle: request/lock/acks in,
// stage resets and status out.
interface rst_release_seq_if #(
  parameter int N_STAGE = 4,
  parameter int STG_W   = 2
);
  logic               rst_req_n;
  logic               pll_locked;
  logic [N_STAGE-1:0] stage_ack;
  logic [N_STAGE-1:0] stage_rst_n;
  logic               seq_done;
  logic               seq_err;
  logic [STG_W-1:0]   err_stage;

  modport master (
    output rst_req_n, pll_locked, stage_ack,
    input  stage_rst_n, seq_done,
    input  seq_err, err_stage
  );

  modport slave (
    input  rst_req_n, pll_locked, stage_ack,
    output stage_rst_n, seq_done,
    output seq_err, err_stage
  );
endinterface

// File: rtl/rst_release_seq.sv
// Ordered stage-reset release after qualified hold; ports:
// clk, rst (async low), bus (rst_release_seq_if.slave).
// Optional ack timeout / ERR state: RST_SEQ_TIMEOUT_EN.
module rst_release_seq #(
  parameter int N_STAGE     = 4,
  parameter int STG_W       = 2,
  parameter int CNT_W       = 8,
  parameter int HOLD_CYC    = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  rst_release_seq_if.slave bus
);

`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_HOLD,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [STG_W-1:0]   r_idx;
  logic [N_STAGE-1:0] r_srn;
  logic               r_done;
  logic               r_err;
  logic [STG_W-1:0]   r_estg;

  logic               w_qual;
  logic               w_ack;
  logic               w_last;
  logic               w_hold_hit;
  logic               w_tmo;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [N_STAGE-1:0] w_nxt;

  assign w_qual     = bus.rst_req_n & bus.pll_locked;
  assign w_ack      = bus.stage_ack[r_idx];
  assign w_last     = r_idx == STG_W'(N_STAGE - 1);
  assign w_hold_hit = r_cnt == CNT_W'(HOLD_CYC - 1);
  // Constant-false without the macro: ERR unreachable.
  assign w_tmo      = TMO_EN &
                      (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_cnt_inc  = (&r_cnt) ? r_cnt
                               : r_cnt + CNT_W'(1);
  assign w_nxt      = N_STAGE'(1) << (r_idx + STG_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_HOLD;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_srn   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_estg  <= '0;
    end else begin
      unique case (r_state)
        S_ERR: begin
          r_srn  <= '0;
          r_done <= 1'b0;
          // Lock is ignored here; only a request clears.
          if (!bus.rst_req_n) begin
            r_state <= S_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            r_estg  <= '0;
          end
        end
        S_HOLD, S_WAIT, S_DONE: begin
          if (!w_qual) begin
            r_state <= S_HOLD;
            r_srn   <= '0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= '0;
          end else if (r_state == S_HOLD) begin
            if (w_hold_hit) begin
              r_state <= S_WAIT;
              r_srn   <= N_STAGE'(1);
              r_cnt   <= '0;
              r_idx   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end else if (r_state == S_WAIT) begin
            // Ack beats a same-edge timeout.
            if (w_ack) begin
              if (w_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end else begin
                r_srn <= r_srn | w_nxt;
                r_idx <= r_idx + STG_W'(1);
                r_cnt <= '0;
              end
            end else if (w_tmo) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
              r_estg  <= r_idx;
              r_srn   <= '0;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
        end
        default: r_state <= S_HOLD;
      endcase
    end
  end

  assign bus.stage_rst_n = r_srn;
  assign bus.seq_done    = r_done;
  assign bus.seq_err     = r_err;
  assign bus.err_stage   = r_estg;

endmodule
